instr_encoder: RTL and testbench
================================

# instr_encoder

Streaming RV32I instruction encoder: accepts decoded instruction fields (class, funct3, funct7 bit 5, rd, rs1, rs2, immediate) over a valid/ready handshake and packs them into 32-bit machine words, written sequentially into instruction memory. It is the inverse of the control decoder and uses the same nine opcode classes. It sits between the test/boot program source and the instruction-memory write port, and is used to load programs and to generate decoder round-trip stimulus.

## Interface
- ADDR_W, 10, instruction-memory word-address width
- BASE_ADDR, 0, word address loaded on reset and on `start`
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  synchronous restart: address <- BASE_ADDR, count/flags cleared
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle this cycle
- in_class  in  4  0 load, 1 store, 2 R, 3 I-ALU, 4 branch, 5 lui, 6 auipc, 7 jal, 8 jalr
- in_funct3  in  3  funct3 (ignored for lui/auipc/jal; forced 000 for jalr)
- in_funct7b5  in  1  instr[30] for R-type and I-ALU shifts
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  immediate, byte offset for branch/jal, full value for lui/auipc (low 12 bits ignored)
- mem_we  out  1  write strobe (also the output valid)
- mem_ready  in  1  memory accepts write this cycle
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  writes completed since reset/start, saturating
- err  out  1  sticky: illegal class or misaligned branch/jal offset
- wrapped  out  1  sticky: address wrapped past all-ones

## Operation
- Two-stage pipeline, each stage with a valid bit: S1 registers the input fields; S2 registers the encoded word (drives mem_wdata, mem_we = S2 valid).
- Handshakes: input accepted when in_valid && in_ready; write complete when mem_we && mem_ready. S2 advances when empty or completing; S1 advances into S2 under the same condition; in_ready = !S1valid || S1 advancing. No bubbles at full throughput (one word/cycle).
- Outputs hold stable while mem_we && !mem_ready.
- Encoding (from S1 fields): load/I-ALU/jalr I-format (imm[11:0]); I-ALU with funct3 001/101: imm[11:5] = {0, funct7b5, 00000}, imm[4:0] = in_imm[4:0]; store S-format; R funct7 = {0, funct7b5, 00000}; branch B-format (imm[12:1]); lui/auipc U-format (imm[31:12]); jal J-format (imm[20:1]). Opcodes: 0000011, 0100011, 0110011, 0010011, 1100011, 0110111, 0010111, 1101111, 1100111.
- Class > 8: emit 0x00000013 (nop), set err. Branch/jal with in_imm[0]=1: encode normally (bit dropped), set err.
- Address: increments on each completed write; from 2^ADDR_W-1 wraps to 0 and sets wrapped. count saturates at all-ones.
- start: clears both pipeline valids (in-flight bundles dropped), address <- BASE_ADDR, count/err/wrapped <- 0; in_ready is 0 in the start cycle. start wins over a simultaneous accept or completion.

## Timing
- Reset (async assert, sync use after deassert): S1/S2 valid 0, mem_we 0, mem_wdata 0, mem_addr BASE_ADDR, count 0, err 0, wrapped 0, in_ready 1 from first cycle after deassert.
- Latency: bundle accepted at edge k -> mem_we=1 with its word from edge k+2.
- Max buffering 2 bundles; with mem_ready held low, in_ready drops two cycles after the stall begins.
- Reset mid-operation: all in-flight bundles discarded, no partial write.

## Test plan
- addi x1,x0,5 (class 3, f3 000, rd 1, imm 5), mem_ready=1 -> mem_wdata 0x00500093 at addr 0, 2 cycles after accept.
- Back-to-back: add x3,x1,x2 / sw x2,8(x1) / beq x1,x2,+8 / lui x5,0x12345000 / jal x1,+8 / srai x1,x1,3 -> 0x002081B3, 0x0020A423, 0x00208463, 0x123452B7, 0x008000EF, 0x4030D093 at addrs 0..5, one per cycle, count=6.
- Backpressure: mem_ready low 4 cycles with continuous input -> in_ready low after 2, mem_wdata/addr stable, no loss or duplication after release.
- class 12 -> 0x00000013 written, err=1; branch imm 0x7 -> err=1, word encodes offset 6.
- ADDR_W=2, 5 writes -> addrs 0,1,2,3,0; wrapped=1 at 5th write; start -> addr BASE_ADDR, flags 0.
- rst_n asserted with S1 and S2 full -> mem_we 0 immediately, outputs at reset values, no write after deassert until new input.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded field bundles into 32-bit words and
// streams them into instruction memory through a two-stage valid/ready pipeline.
module instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_class,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7b5,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic              wrapped
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   COUNT_MAX = {(ADDR_W+1){1'b1}};
  localparam logic [31:0]       NOP_WORD  = 32'h0000_0013;

  function automatic logic [31:0] encodeWord(
    input logic [3:0]  cls,
    input logic [2:0]  f3,
    input logic        f7b5,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    logic [31:0] w;
    w = NOP_WORD;
    case (cls)
      4'd0: w = {imm[11:0], rs1, f3, rd, 7'b0000011};
      4'd1: w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      4'd2: w = {1'b0, f7b5, 5'b00000, rs2, rs1, f3, rd, 7'b0110011};
      4'd3: begin
        // Shift-immediates carry the arithmetic/logical select in imm[10].
        if (f3 == 3'b001 || f3 == 3'b101) begin
          w = {1'b0, f7b5, 5'b00000, imm[4:0], rs1, f3, rd, 7'b0010011};
        end else begin
          w = {imm[11:0], rs1, f3, rd, 7'b0010011};
        end
      end
      4'd4: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
      4'd5: w = {imm[31:12], rd, 7'b0110111};
      4'd6: w = {imm[31:12], rd, 7'b0010111};
      4'd7: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      4'd8: w = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      default: w = NOP_WORD;
    endcase
    return w;
  endfunction

  function automatic logic isBad(input logic [3:0] cls, input logic imm0);
    return (cls > 4'd8) || (((cls == 4'd4) || (cls == 4'd7)) && imm0);
  endfunction

  logic              s1Valid_r;
  logic [3:0]        s1Class_r;
  logic [2:0]        s1Funct3_r;
  logic              s1Funct7b5_r;
  logic [4:0]        s1Rd_r;
  logic [4:0]        s1Rs1_r;
  logic [4:0]        s1Rs2_r;
  logic [31:0]       s1Imm_r;
  logic              s2Valid_r;
  logic [31:0]       s2Word_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W:0]   count_r;
  logic              err_r;
  logic              wrapped_r;

  logic              s2Adv_s;
  logic              s1Adv_s;
  logic              inReady_s;
  logic              accept_s;
  logic              writeDone_s;
  logic [31:0]       encWord_s;
  logic              encBad_s;

  // Handshake decode and encoding of the S1 bundle.
  always_comb begin
    s2Adv_s     = 1'b0;
    inReady_s   = 1'b0;
    s2Adv_s     = !s2Valid_r || mem_ready;
    s1Adv_s     = s1Valid_r && s2Adv_s;
    writeDone_s = s2Valid_r && mem_ready;
    if (start) begin
      inReady_s = 1'b0;
    end else begin
      inReady_s = !s1Valid_r || s2Adv_s;
    end
    accept_s  = in_valid && inReady_s;
    encWord_s = encodeWord(s1Class_r, s1Funct3_r, s1Funct7b5_r, s1Rd_r, s1Rs1_r, s1Rs2_r, s1Imm_r);
    encBad_s  = isBad(s1Class_r, s1Imm_r[0]);
  end

  // Pipeline stages S1 (fields) and S2 (encoded word).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_r    <= 1'b0;
      s1Class_r    <= 4'd0;
      s1Funct3_r   <= 3'd0;
      s1Funct7b5_r <= 1'b0;
      s1Rd_r       <= 5'd0;
      s1Rs1_r      <= 5'd0;
      s1Rs2_r      <= 5'd0;
      s1Imm_r      <= 32'd0;
      s2Valid_r    <= 1'b0;
      s2Word_r     <= 32'd0;
    end else if (start) begin
      s1Valid_r <= 1'b0;
      s2Valid_r <= 1'b0;
    end else begin
      if (accept_s) begin
        s1Valid_r    <= 1'b1;
        s1Class_r    <= in_class;
        s1Funct3_r   <= in_funct3;
        s1Funct7b5_r <= in_funct7b5;
        s1Rd_r       <= in_rd;
        s1Rs1_r      <= in_rs1;
        s1Rs2_r      <= in_rs2;
        s1Imm_r      <= in_imm;
      end else if (s1Adv_s) begin
        s1Valid_r <= 1'b0;
      end
      if (s2Adv_s) begin
        s2Valid_r <= s1Valid_r;
        if (s1Valid_r) begin
          s2Word_r <= encWord_s;
        end
      end
    end
  end

  // Write address, completed-write count and sticky status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r    <= BASE;
      count_r   <= {(ADDR_W+1){1'b0}};
      err_r     <= 1'b0;
      wrapped_r <= 1'b0;
    end else if (start) begin
      addr_r    <= BASE;
      count_r   <= {(ADDR_W+1){1'b0}};
      err_r     <= 1'b0;
      wrapped_r <= 1'b0;
    end else begin
      // err latches as the offending bundle is encoded into S2.
      if (s1Adv_s && encBad_s) begin
        err_r <= 1'b1;
      end
      if (writeDone_s) begin
        addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (addr_r == ADDR_MAX) begin
          wrapped_r <= 1'b1;
        end
        if (count_r != COUNT_MAX) begin
          count_r <= count_r + {{ADDR_W{1'b0}}, 1'b1};
        end
      end
    end
  end

  assign in_ready  = inReady_s;
  assign mem_we    = s2Valid_r;
  assign mem_wdata = s2Word_r;
  assign mem_addr  = addr_r;
  assign count     = count_r;
  assign err       = err_r;
  assign wrapped   = wrapped_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors, a field-level encoding
// model and a scoreboard of expected memory writes checked every cycle.
module tb_instr_encoder;

  localparam int AW = 3;
  localparam logic [AW-1:0] BASE = 3'd0;
  localparam logic [AW-1:0] AMAX = 3'd7;
  localparam logic [AW:0]   CMAX = 4'd15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_class;
  logic [2:0]    in_funct3;
  logic          in_funct7b5;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [31:0]   in_imm;
  logic          mem_we;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
  logic          err;
  logic          wrapped;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .count(count), .err(err), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference encoding built from bit positions with shifts and masks.
  function automatic logic [31:0] mdlWord(input logic [3:0] c, input logic [2:0] f3, input logic f7,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] r, a, b, f, i12;
    r   = 32'(rd) << 7;
    a   = 32'(rs1) << 15;
    b   = 32'(rs2) << 20;
    f   = 32'(f3) << 12;
    i12 = (imm & 32'h0000_0fff) << 20;
    case (c)
      4'd0: return i12 | a | f | r | 32'd3;
      4'd1: return (((imm >> 5) & 32'h7f) << 25) | b | a | f | ((imm & 32'h1f) << 7) | 32'd35;
      4'd2: return (32'(f7) << 30) | b | a | f | r | 32'd51;
      4'd3: begin
        if (f3 == 3'd1 || f3 == 3'd5) return (32'(f7) << 30) | ((imm & 32'h1f) << 20) | a | f | r | 32'd19;
        else return i12 | a | f | r | 32'd19;
      end
      4'd4: return (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'h3f) << 25) | b | a | f
                   | (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 32'd1) << 7) | 32'd99;
      4'd5: return (imm & 32'hffff_f000) | r | 32'd55;
      4'd6: return (imm & 32'hffff_f000) | r | 32'd23;
      4'd7: return (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'h3ff) << 21)
                   | (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'hff) << 12) | r | 32'd111;
      4'd8: return i12 | a | r | 32'd103;
      default: return 32'd19;
    endcase
  endfunction

  function automatic logic mdlBad(input logic [3:0] c, input logic [31:0] imm);
    return (c > 4'd8) || ((c == 4'd4 || c == 4'd7) && imm[0]);
  endfunction

  typedef struct { logic [31:0] word; logic bad; } exp_t;
  exp_t          expQ[$];
  logic [AW-1:0] expAddr = BASE;
  logic [AW:0]   expCount = '0;
  logic          expErr = 1'b0;
  logic          expWrapped = 1'b0;
  logic          prevStall = 1'b0;
  logic [31:0]   prevWord;
  logic [AW-1:0] prevAddr;

  // Compare process: checks outputs every cycle, then advances the model.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'(BASE));
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_flags", {30'd0, err, wrapped}, 32'd0);
      expQ.delete();
      expAddr = BASE; expCount = '0; expErr = 1'b0; expWrapped = 1'b0; prevStall = 1'b0;
    end else begin
      chk("addr", 32'(mem_addr), 32'(expAddr));
      chk("count", 32'(count), 32'(expCount));
      chk("wrapped", 32'(wrapped), 32'(expWrapped));
      if (mem_we) begin
        if (expQ.size() == 0) begin
          chk("spurious_we", 32'(mem_we), 32'd0);
        end else begin
          chk("wdata", mem_wdata, expQ[0].word);
          chk("err", 32'(err), 32'(expErr | expQ[0].bad));
        end
        if (prevStall) begin
          chk("hold_wdata", mem_wdata, prevWord);
          chk("hold_addr", 32'(mem_addr), 32'(prevAddr));
        end
      end else begin
        chk("err", 32'(err), 32'(expErr));
      end
      if (start) begin
        chk("start_ready", 32'(in_ready), 32'd0);
        expQ.delete();
        expAddr = BASE; expCount = '0; expErr = 1'b0; expWrapped = 1'b0; prevStall = 1'b0;
      end else begin
        prevStall = mem_we && !mem_ready;
        prevWord  = mem_wdata;
        prevAddr  = mem_addr;
        if (mem_we && mem_ready && expQ.size() > 0) begin
          e = expQ.pop_front();
          expErr = expErr | e.bad;
          if (expAddr == AMAX) expWrapped = 1'b1;
          expAddr = expAddr + 3'd1;
          if (expCount != CMAX) expCount = expCount + 4'd1;
        end
        if (in_valid && in_ready) begin
          e.word = mdlWord(in_class, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm);
          e.bad  = mdlBad(in_class, in_imm);
          expQ.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] c, input logic [2:0] f3, input logic f7, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    logic acc;
    in_class = c; in_funct3 = f3; in_funct7b5 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready && !start;
      tick();
    end
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] rdyPat;
    longint     t0;
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
    in_class = 4'd0; in_funct3 = 3'd0; in_funct7b5 = 1'b0;
    in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;

    // Hand-computed words pin the model.
    chk("pin_addi", mdlWord(4'd3, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5), 32'h0050_0093);
    chk("pin_add",  mdlWord(4'd2, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0), 32'h0020_81B3);
    chk("pin_sw",   mdlWord(4'd1, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8), 32'h0020_A423);
    chk("pin_beq",  mdlWord(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8), 32'h0020_8463);
    chk("pin_lui",  mdlWord(4'd5, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000), 32'h1234_52B7);
    chk("pin_jal",  mdlWord(4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8), 32'h0080_00EF);
    chk("pin_srai", mdlWord(4'd3, 3'd5, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3), 32'h4030_D093);
    chk("pin_bad",  mdlWord(4'd12, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd0), 32'h0000_0013);
    chk("pin_bodd", mdlWord(4'd4, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd7), 32'h0000_0363);
    chk("pin_jalr", mdlWord(4'd8, 3'd7, 1'b0, 5'd1, 5'd2, 5'd0, 32'd4), 32'h0041_00E7);

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(in_ready), 32'd1);
    chk("reset_we", 32'(mem_we), 32'd0);
    chk("reset_wdata", mem_wdata, 32'd0);
    chk("reset_addr", 32'(mem_addr), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_flags", {30'd0, err, wrapped}, 32'd0);
    tick();

    // Single addi: word visible for the write one cycle after S1 captures it.
    send(4'd3, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_we_early", 32'(mem_we), 32'd0);
    tick();
    @(negedge clk);
    chk("lat_we", 32'(mem_we), 32'd1);
    chk("lat_wdata", mem_wdata, 32'h0050_0093);
    chk("lat_addr", 32'(mem_addr), 32'd0);
    repeat (3) tick();

    // Back-to-back at full rate from address 0.
    pulseStart();
    t0 = $time;
    send(4'd2, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    send(4'd1, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
    send(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
    send(4'd5, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
    send(4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
    send(4'd3, 3'd5, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3);
    in_valid = 1'b0;
    chk("b2b_cycles", 32'(($time - t0) / 10), 32'd6);
    repeat (4) tick();
    @(negedge clk);
    chk("b2b_count", 32'(count), 32'd6);
    chk("b2b_addr", 32'(mem_addr), 32'd6);
    tick();

    // Backpressure: memory stalls four cycles while input keeps coming.
    fork
      begin
        send(4'd0, 3'd2, 1'b0, 5'd4, 5'd2, 5'd0, 32'h0000_0ffc);
        send(4'd6, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'hfedc_b123);
        send(4'd2, 3'd0, 1'b1, 5'd8, 5'd9, 5'd10, 32'd0);
        send(4'd8, 3'd0, 1'b0, 5'd0, 5'd1, 5'd0, 32'h0000_0800);
        send(4'd7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hfff0_0ffe);
        send(4'd3, 3'd1, 1'b0, 5'd2, 5'd2, 5'd0, 32'h0000_0ff1);
        in_valid = 1'b0;
      end
      begin
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          rdyPat[i] = in_ready;
          tick();
        end
        mem_ready = 1'b1;
      end
    join
    chk("bp_ready_pattern", 32'(rdyPat), 32'h3);
    repeat (4) tick();
    @(negedge clk);
    chk("bp_drained", 32'(expQ.size()), 32'd0);
    chk("bp_count", 32'(count), 32'd12);
    chk("bp_addr", 32'(mem_addr), 32'd4);
    chk("bp_wrapped", 32'(wrapped), 32'd1);
    chk("bp_err_clear", 32'(err), 32'd0);
    tick();

    // Illegal class and odd branch offset.
    send(4'd12, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd0);
    send(4'd4, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd7);
    in_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("err_set", 32'(err), 32'd1);
    chk("err_count", 32'(count), 32'd14);
    tick();

    // Wrap twice and saturate the count, then restart.
    pulseStart();
    @(negedge clk);
    chk("start_state", {24'd0, count, mem_addr, err}, 32'd0);
    tick();
    for (int i = 0; i < 17; i++) send(4'd3, 3'd0, 1'b0, 5'(i), 5'd1, 5'd0, 32'(i * 3));
    in_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("sat_count", 32'(count), 32'd15);
    chk("sat_addr", 32'(mem_addr), 32'd1);
    chk("sat_wrapped", 32'(wrapped), 32'd1);
    tick();
    pulseStart();
    @(negedge clk);
    chk("restart_addr", 32'(mem_addr), 32'(BASE));
    chk("restart_flags", {27'd0, count, wrapped}, 32'd0);
    tick();

    // Reset with both stages holding bundles.
    mem_ready = 1'b0;
    send(4'd3, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);
    send(4'd3, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_we", 32'(mem_we), 32'd0);
    chk("midrst_wdata", mem_wdata, 32'd0);
    chk("midrst_addr", 32'(mem_addr), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    chk("post_rst_idle", 32'(mem_we), 32'd0);
    tick();
    send(4'd8, 3'd7, 1'b0, 5'd1, 5'd2, 5'd0, 32'd4);
    in_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("final_count", 32'(count), 32'd1);
    chk("final_drain", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
